// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - RV32I fetch stage: PC, credit-limited imem requests, instruction FIFO, redirects.
// Optional IFU_ILLEGAL_CHECK_EN: tag non-32-bit encodings as faults and halt fetch until redirect.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] instruction,
  output logic [31:0] inst_pc,
  output logic        fetch_fault
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic [31:0]     resp_pc_q, resp_pc_d;
  logic            req_valid_q, req_valid_d;
  logic [31:0]     req_addr_q, req_addr_d;
  logic [CW-1:0]   outstanding_q, outstanding_d;
  logic [CW-1:0]   drop_cnt_q, drop_cnt_d;
  logic [CW-1:0]   count_q, count_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [31:0]     data_mem [FIFO_DEPTH];
  logic [31:0]     pc_mem   [FIFO_DEPTH];

  logic            accept, push, pop, hold, credit_ok;
  logic [31:0]     redirect_target;
  logic            unused_redirect_lsb;

  assign accept              = req_valid_q && imem_req_ready;
  assign push                = imem_resp_valid && (drop_cnt_q == '0) && (state_q == RUN) && !redirect_valid;
  assign pop                 = (count_q != '0) && inst_ready && !redirect_valid;
  assign redirect_target     = {redirect_pc[31:2], 2'b00};
  assign unused_redirect_lsb = ^redirect_pc[1:0];

`ifdef IFU_ILLEGAL_CHECK_EN
  logic fault_mem [FIFO_DEPTH];
  logic resp_fault;
  assign resp_fault  = (imem_resp_data[1:0] != 2'b11);
  assign fetch_fault = inst_valid && fault_mem[rd_ptr_q];
`else
  assign fetch_fault = 1'b0;
`endif

  always_comb begin
    outstanding_d = outstanding_q;
    drop_cnt_d    = drop_cnt_q;
    count_d       = count_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    state_d       = state_q;

    case ({accept, imem_resp_valid})
      2'b10:   outstanding_d = outstanding_q + CW'(1);
      2'b01:   outstanding_d = outstanding_q - CW'(1);
      default: outstanding_d = outstanding_q;
    endcase
    if (imem_resp_valid && (drop_cnt_q != '0)) drop_cnt_d = drop_cnt_q - CW'(1);

    if (push && !pop) count_d = count_q + CW'(1);
    if (pop && !push) count_d = count_q - CW'(1);
    if (push) begin
      wr_ptr_d  = wr_ptr_q + AW'(1);
      resp_pc_d = resp_pc_q + 32'd4;
    end
    if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
    if (accept) fetch_pc_d = fetch_pc_q + 32'd4;

`ifdef IFU_ILLEGAL_CHECK_EN
    if (push && resp_fault) state_d = HALT;
`endif

    // Everything still in flight after this cycle's accept/response is stale.
    if (redirect_valid) begin
      count_d    = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      drop_cnt_d = outstanding_d;
      fetch_pc_d = redirect_target;
      resp_pc_d  = redirect_target;
      state_d    = RUN;
    end

    hold        = req_valid_q && !accept && !redirect_valid;
    credit_ok   = ({1'b0, outstanding_d} + {1'b0, count_d}) < (CW + 1)'(FIFO_DEPTH);
    req_valid_d = (state_d == RUN) && (hold || credit_ok);
    req_addr_d  = fetch_pc_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= RUN;
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      req_valid_q   <= 1'b0;
      req_addr_q    <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
      count_q       <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      req_valid_q   <= req_valid_d;
      req_addr_q    <= req_addr_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
      count_q       <= count_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        data_mem[i] <= '0;
        pc_mem[i]   <= '0;
`ifdef IFU_ILLEGAL_CHECK_EN
        fault_mem[i] <= 1'b0;
`endif
      end
    end else if (push) begin
      data_mem[wr_ptr_q] <= imem_resp_data;
      pc_mem[wr_ptr_q]   <= resp_pc_q;
`ifdef IFU_ILLEGAL_CHECK_EN
      fault_mem[wr_ptr_q] <= resp_fault;
`endif
    end
  end

  assign imem_req_valid = req_valid_q;
  assign imem_req_addr  = req_addr_q;
  assign inst_valid     = (count_q != '0);
  assign instruction    = data_mem[rd_ptr_q];
  assign inst_pc        = pc_mem[rd_ptr_q];

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb/tb_instruction_fetch_unit.sv - directed self-checking bench for instruction_fetch_unit.
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = '0;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] instruction;
  logic [31:0] inst_pc;
  logic        fetch_fault;

  int checks = 0;
  int errors = 0;
  int accept_cnt = 0;
  logic resp_hold = 1'b0;
  logic [31:0] pend_q[$];

  instruction_fetch_unit #(.RESET_PC(32'h0), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .instruction(instruction),
    .inst_pc(inst_pc), .fetch_fault(fetch_fault)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    if (a == 32'h200) return 32'h0000_4501;
    return {a[23:0], 8'h13};
  endfunction

  // Memory model: answers in order, one cycle after accept unless held.
  always @(posedge clk) begin
    if (!rst_n) pend_q.delete();
    else if (imem_req_valid && imem_req_ready) begin
      pend_q.push_back(imem_req_addr);
      accept_cnt++;
    end
    #1;
    if (rst_n && !resp_hold && pend_q.size() != 0) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = word_at(pend_q.pop_front());
    end else begin
      imem_resp_valid = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_inst(input string tag, input int limit);
    int k = 0;
    while (!inst_valid && k < limit) begin
      tick();
      k++;
    end
    chk(tag, {31'b0, inst_valid}, 32'h1);
  endtask

  task automatic wait_req(input string tag, input int limit);
    int k = 0;
    while (!imem_req_valid && k < limit) begin
      tick();
      k++;
    end
    chk(tag, {31'b0, imem_req_valid}, 32'h1);
  endtask

  task automatic pulse_redirect(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    tick();
    redirect_valid = 1'b0;
  endtask

  initial begin
    int n;
    int acc_snap;
    logic [31:0] exp_pc;

    rst_n = 1'b0; imem_req_ready = 1'b1; inst_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0;
    tick(); tick();
    chk("rst_req_valid", {31'b0, imem_req_valid}, 32'h0);
    chk("rst_req_addr", imem_req_addr, 32'h0);
    chk("rst_inst_valid", {31'b0, inst_valid}, 32'h0);
    chk("rst_instruction", instruction, 32'h0);
    chk("rst_inst_pc", inst_pc, 32'h0);
    chk("rst_fault", {31'b0, fetch_fault}, 32'h0);

    // First request, then backpressure until FIFO fills
    rst_n = 1'b1;
    tick();
    chk("t1_req_valid", {31'b0, imem_req_valid}, 32'h1);
    chk("t1_req_addr0", imem_req_addr, 32'h0);
    tick();
    chk("t1_req_addr4", imem_req_addr, 32'h4);
    tick();
    chk("t1_inst_valid", {31'b0, inst_valid}, 32'h1);
    chk("t1_inst_pc", inst_pc, 32'h0);
    chk("t1_instruction", instruction, 32'h0000_0013);
    chk("t3_req_stop", {31'b0, imem_req_valid}, 32'h0);
    tick(); tick(); tick(); tick();
    chk("t3_accepts", accept_cnt, 32'd2);
    chk("t3_req_idle", {31'b0, imem_req_valid}, 32'h0);
    chk("t3_head_pc", inst_pc, 32'h0);

    inst_ready = 1'b1;
    tick();
    chk("t3_resume_valid", {31'b0, imem_req_valid}, 32'h1);
    chk("t3_resume_addr", imem_req_addr, 32'h8);
    chk("t3_head_after_pop", inst_pc, 32'h4);

    // Streaming: PCs must arrive in order with matching words
    exp_pc = 32'h4;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (inst_valid) begin
        chk("t2_pc", inst_pc, exp_pc);
        chk("t2_word", instruction, word_at(exp_pc));
        exp_pc = exp_pc + 32'd4;
        n++;
      end
      tick();
    end
    chk("t2_count_ok", {31'b0, (n >= 6)}, 32'h1);

    // Redirect with two requests outstanding
    resp_hold = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    chk("t4_pre_req", {31'b0, imem_req_valid}, 32'h0);
    chk("t4_pre_inst", {31'b0, inst_valid}, 32'h0);
    chk("t4_outstanding", pend_q.size(), 32'd2);
    pulse_redirect(32'h0000_0103);
    chk("t4_flush", {31'b0, inst_valid}, 32'h0);
    resp_hold = 1'b0;
    wait_req("t4_wait_req", 10);
    chk("t4_req_addr", imem_req_addr, 32'h100);
    wait_inst("t4_wait_inst", 10);
    chk("t4_inst_pc", inst_pc, 32'h100);
    chk("t4_word", instruction, 32'h0001_0013);

    // Async reset with FIFO full
    inst_ready = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    chk("t5_full", {31'b0, inst_valid}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("t5_inst_valid", {31'b0, inst_valid}, 32'h0);
    chk("t5_req_valid", {31'b0, imem_req_valid}, 32'h0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("t5_refetch_valid", {31'b0, imem_req_valid}, 32'h1);
    chk("t5_refetch_addr", imem_req_addr, 32'h0);
    inst_ready = 1'b1;
    wait_inst("t5_wait_inst", 10);
    chk("t5_inst_pc", inst_pc, 32'h0);

    // Compressed/invalid encoding at 0x200
    pulse_redirect(32'h0000_0200);
    wait_inst("t6_wait_inst", 10);
    chk("t6_inst_pc", inst_pc, 32'h200);
    chk("t6_word", instruction, 32'h0000_4501);
`ifdef IFU_ILLEGAL_CHECK_EN
    chk("t6_fault", {31'b0, fetch_fault}, 32'h1);
    tick(); tick(); tick();
    acc_snap = accept_cnt;
    for (int i = 0; i < 6; i++) tick();
    chk("t6_halt_accepts", accept_cnt, acc_snap);
    chk("t6_halt_req", {31'b0, imem_req_valid}, 32'h0);
    chk("t6_halt_inst", {31'b0, inst_valid}, 32'h0);
    pulse_redirect(32'h0000_0000);
    wait_inst("t6_resume_inst", 10);
    chk("t6_resume_pc", inst_pc, 32'h0);
    chk("t6_resume_fault", {31'b0, fetch_fault}, 32'h0);
`else
    chk("t6_fault", {31'b0, fetch_fault}, 32'h0);
    acc_snap = accept_cnt;
    tick();
    wait_inst("t6_next_inst", 10);
    chk("t6_next_pc", inst_pc, 32'h204);
    chk("t6_next_fault", {31'b0, fetch_fault}, 32'h0);
    for (int i = 0; i < 4; i++) tick();
    chk("t6_still_fetching", {31'b0, (accept_cnt > acc_snap)}, 32'h1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
